// File: rtl/npu_argmax_unit.sv
// Streaming arg-max unit: reduces each frame of NUM_CLASSES scores, delivered
// LANES per beat, to a winning class index and score held in a one-entry
// valid/ready result register. Ties resolve to the lowest class index.
module npu_argmax_unit #(
  parameter int DATA_W      = 8,
  parameter int LANES       = 4,
  parameter int NUM_CLASSES = 10,
  parameter int SIGNED      = 1,
  localparam int CLS_W      = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
  input  logic                    CLKEXT,
  input  logic                    RST_GLO_N,
  input  logic                    EN_COMP,
  input  logic                    CLR_COMP,
  input  logic                    IN_VALID,
  input  logic [LANES*DATA_W-1:0] IN_DATA,
  input  logic                    OUT_READY,
  output logic                    OUT_VALID,
  output logic [CLS_W-1:0]        OUT_CLASS,
  output logic [DATA_W-1:0]       OUT_SCORE,
  output logic                    OVERRUN,
  output logic [7:0]              FRAME_CNT,
  output logic                    BUSY
);

  localparam int BEATS = (NUM_CLASSES + LANES - 1) / LANES;
  localparam int BI_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [BI_W-1:0]   beat_idx_q,  beat_idx_d;
  logic [DATA_W-1:0] run_score_q, run_score_d;
  logic [CLS_W-1:0]  run_class_q, run_class_d;
  logic              out_valid_q, out_valid_d;
  logic [CLS_W-1:0]  out_class_q, out_class_d;
  logic [DATA_W-1:0] out_score_q, out_score_d;
  logic              overrun_q,   overrun_d;
  logic [7:0]        frame_cnt_q, frame_cnt_d;

  logic [DATA_W-1:0] bw_score;
  logic [CLS_W-1:0]  bw_class;
  logic [DATA_W-1:0] mg_score;
  logic [CLS_W-1:0]  mg_class;
  logic              last_beat;

  // Strict greater-than in the configured number representation
  function automatic logic score_gt(input logic [DATA_W-1:0] a,
                                    input logic [DATA_W-1:0] b);
    if (SIGNED != 0) score_gt = ($signed(a) > $signed(b));
    else             score_gt = (a > b);
  endfunction

  // Beat winner: scan lanes upward, replace only on strictly greater, skip padding
  always_comb begin
    bw_score = IN_DATA[DATA_W-1:0];
    bw_class = CLS_W'(int'(beat_idx_q) * LANES);
    for (int k = 1; k < LANES; k++) begin
      if (((int'(beat_idx_q) * LANES + k) < NUM_CLASSES) &&
          score_gt(IN_DATA[k*DATA_W +: DATA_W], bw_score)) begin
        bw_score = IN_DATA[k*DATA_W +: DATA_W];
        bw_class = CLS_W'(int'(beat_idx_q) * LANES + k);
      end
    end
  end

  // Merge beat winner into running max; beat 0 starts a fresh frame
  always_comb begin
    last_beat = (beat_idx_q == BI_W'(BEATS - 1));
    if ((beat_idx_q == '0) || score_gt(bw_score, run_score_q)) begin
      mg_score = bw_score;
      mg_class = bw_class;
    end else begin
      mg_score = run_score_q;
      mg_class = run_class_q;
    end
  end

  // Next-state: freeze, clear, then beat accept / frame completion / handshake
  always_comb begin
    beat_idx_d  = beat_idx_q;
    run_score_d = run_score_q;
    run_class_d = run_class_q;
    out_valid_d = out_valid_q;
    out_class_d = out_class_q;
    out_score_d = out_score_q;
    overrun_d   = overrun_q;
    frame_cnt_d = frame_cnt_q;
    if (EN_COMP) begin
      if (CLR_COMP) begin
        beat_idx_d  = '0;
        run_score_d = '0;
        run_class_d = '0;
        out_valid_d = 1'b0;
        out_class_d = '0;
        out_score_d = '0;
        overrun_d   = 1'b0;
        frame_cnt_d = 8'd0;
      end else begin
        if (out_valid_q && OUT_READY) out_valid_d = 1'b0;
        if (IN_VALID) begin
          run_score_d = mg_score;
          run_class_d = mg_class;
          if (last_beat) begin
            beat_idx_d  = '0;
            frame_cnt_d = frame_cnt_q + 8'd1;
            // Result slot is free if empty or draining this very cycle
            if (!out_valid_q || OUT_READY) begin
              out_valid_d = 1'b1;
              out_class_d = mg_class;
              out_score_d = mg_score;
            end else begin
              overrun_d = 1'b1;
            end
          end else begin
            beat_idx_d = beat_idx_q + BI_W'(1);
          end
        end
      end
    end
  end

  // State register; async reset drops any partial frame at once
  always_ff @(posedge CLKEXT or negedge RST_GLO_N) begin
    if (!RST_GLO_N) begin
      beat_idx_q  <= '0;
      run_score_q <= '0;
      run_class_q <= '0;
      out_valid_q <= 1'b0;
      out_class_q <= '0;
      out_score_q <= '0;
      overrun_q   <= 1'b0;
      frame_cnt_q <= 8'd0;
    end else begin
      beat_idx_q  <= beat_idx_d;
      run_score_q <= run_score_d;
      run_class_q <= run_class_d;
      out_valid_q <= out_valid_d;
      out_class_q <= out_class_d;
      out_score_q <= out_score_d;
      overrun_q   <= overrun_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign OUT_VALID = out_valid_q;
  assign OUT_CLASS = out_class_q;
  assign OUT_SCORE = out_score_q;
  assign OVERRUN   = overrun_q;
  assign FRAME_CNT = frame_cnt_q;
  assign BUSY      = (beat_idx_q != '0);

endmodule

// File: doc/npu_argmax_unit.md
# npu_argmax_unit

Parametrised streaming arg-max unit for the NPU output stage. It consumes class scores from the output layer, LANES scores per beat, and reduces each frame of NUM_CLASSES scores to a winning class index and score. It holds that result in a one-entry valid/ready output register. It replaces the fixed 4-lane, 8-bit AUTO_COMP path: width, lane count, class count and signedness are configurable, and it adds output back-pressure, overrun detection and a frame counter.

## Interface
- DATA_W, 8: score width in bits.
- LANES, 4: scores per input beat.
- NUM_CLASSES, 10: scores per frame; must be ≥ 2.
- SIGNED, 1: 1 = two's-complement compare, 0 = unsigned compare.
- Derived, not overridable:
  - CLS_W = clog2(NUM_CLASSES).
  - BEATS = ceil(NUM_CLASSES/LANES).

- CLKEXT  in  1  clock; all logic is rising-edge.
- RST_GLO_N  in  1  asynchronous, active-low reset.
- EN_COMP  in  1  unit enable; when low all state is frozen and IN_VALID is ignored.
- CLR_COMP  in  1  synchronous clear of frame state, result, OVERRUN and FRAME_CNT; effective only when EN_COMP=1.
- IN_VALID  in  1  IN_DATA holds a beat. There is no input ready: a beat is always accepted when EN_COMP=1.
- IN_DATA  in  LANES*DATA_W  lane k occupies bits [k*DATA_W +: DATA_W] and carries class beat_idx*LANES+k.
- OUT_READY  in  1  consumer accepts the result.
- OUT_VALID  out  1  result register full.
- OUT_CLASS  out  CLS_W  winning class index.
- OUT_SCORE  out  DATA_W  winning score.
- OVERRUN  out  1  sticky flag: a completed frame was dropped because the result register was full.
- FRAME_CNT  out  8  number of frames completed (stored or dropped); wraps from 255 to 0.
- BUSY  out  1  high when beat_idx ≠ 0, i.e. a frame is partially received.

## Operation
- Beat counter beat_idx runs 0..BEATS-1. It increments on each accepted beat and wraps to 0 after the final beat.
- Per-beat lane reduction (combinational):
  - Lanes whose class index is ≥ NUM_CLASSES (padding in the final beat) are excluded.
  - Within the beat, a lane replaces the current candidate only if it is strictly greater. Ties therefore go to the lower class index.
- Running max register (run_score, run_class):
  - On beat 0, it is loaded unconditionally with the beat winner.
  - On later beats, it is replaced only if the beat winner is strictly greater than run_score, so ties across beats keep the earlier class.
- Frame completion = accepted beat with beat_idx = BEATS-1. The final result is the max of run_* and that beat's winner.
  - If OUT_VALID=0, or OUT_VALID=1 and OUT_READY=1 in the same cycle, the result register loads the new result and OUT_VALID=1.
  - Otherwise the new result is dropped, the old result is kept, and OVERRUN is set.
  - FRAME_CNT increments in both cases.
- Output handshake:
  - A transfer occurs when OUT_VALID=1 and OUT_READY=1.
  - OUT_VALID clears after a transfer unless a new result loads in the same cycle.
  - OUT_CLASS and OUT_SCORE are stable while OUT_VALID=1 and OUT_READY=0.
- Priority, highest first: RST_GLO_N low; EN_COMP low (freeze); CLR_COMP; normal operation. CLR_COMP has priority over an IN_VALID beat and over an output transfer in the same cycle.
- CLR_COMP effect: beat_idx=0, run_* =0, OUT_VALID=0, OUT_CLASS=0, OUT_SCORE=0, OVERRUN=0, FRAME_CNT=0.
- Degenerate case: if LANES ≥ NUM_CLASSES then BEATS=1, and every accepted beat is a full frame.

## Timing
- Reset values: OUT_VALID=0, OUT_CLASS=0, OUT_SCORE=0, OVERRUN=0, FRAME_CNT=0, BUSY=0; internal beat_idx=0, run_*=0.
- Reset assertion mid-frame discards the partial frame immediately, without waiting for a clock edge.
- Latency: OUT_VALID rises on the clock edge that accepts the final beat, i.e. visible 1 cycle after that beat is presented.
- Throughput: 1 beat per cycle, back-to-back frames with no bubble. Sustained rate is one result per BEATS cycles when OUT_READY is held high.
- OVERRUN and FRAME_CNT update on the same edge as the completing beat.
- BUSY falls on the edge that accepts the final beat.

## Test plan
Defaults for all scenarios: DATA_W=8, LANES=4, NUM_CLASSES=10, BEATS=3.
1. Reset: hold RST_GLO_N=0 with random inputs -> all outputs 0. Release, then 2 idle cycles -> outputs still 0.
2. Basic frame, SIGNED=1, OUT_READY=1:
   - Stimulus: beats {0x10,0x20,0x05,0x7F}, {0x00,0x01,0x02,0x03}, {0x40,0x7E,0x7F,0x7F}.
   - Response: 1 cycle after beat 3, OUT_VALID=1, OUT_CLASS=3, OUT_SCORE=0x7F, FRAME_CNT=1. The lane 2/3 padding (0x7F) is ignored.
3. Signedness and ties:
   - SIGNED=1, all scores 0x80 except class 7 = 0xFF -> class 7, score 0xFF.
   - SIGNED=0, same data -> class 7 (0xFF is largest).
   - Classes 1 and 6 both 0x50, all others 0x00 -> class 1.
4. Back-pressure and overrun, OUT_READY=0:
   - Stream two frames with winners class 2 and class 9 -> result holds class 2, OVERRUN=1, FRAME_CNT=2.
   - Then raise OUT_READY for 1 cycle -> OUT_VALID=0, OVERRUN stays 1.
5. Clear and freeze:
   - Send 1 beat, then pulse CLR_COMP concurrently with an IN_VALID beat -> that beat is discarded and BUSY=0; the next 3 beats form a complete frame.
   - EN_COMP=0 for 4 cycles mid-frame with IN_VALID=1 -> no state change; the frame resumes correctly afterwards.
6. Async reset mid-frame: drop RST_GLO_N between beats 2 and 3 -> outputs 0 immediately. After release, a full 3-beat frame produces the correct result with FRAME_CNT=1.
